// File: rtl/uart_apb_master.sv
// UART-to-APB debug bridge: framed commands on rx_i drive one APB transfer each; status/read data return on tx_o.
// Optional inter-byte timeout: define UART_APB_MASTER_TIMEOUT_EN.
module uart_apb_master #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int CLKS_PER_BIT   = 868,
  parameter int TIMEOUT_BITS   = 40
) (
  input  logic                      CLK,
  input  logic                      RSTN,
  input  logic                      rx_i,
  output logic                      tx_o,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]               PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [31:0]               PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR,
  output logic                      busy_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [7:0] CMD_WRITE   = 8'h57;
  localparam logic [7:0] CMD_READ    = 8'h52;
  localparam logic [7:0] RSP_OK      = 8'h4B;
  localparam logic [7:0] RSP_ERR     = 8'h45;
  localparam logic [7:0] RSP_UNKNOWN = 8'h3F;

  if ((CLKS_PER_BIT < 4) || (TIMEOUT_BITS < 1) || (APB_ADDR_WIDTH < 1) || (APB_ADDR_WIDTH > 16)) begin : g_bad_params
    $error("uart_apb_master: illegal parameter value");
  end

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {C_IDLE, C_ADDR, C_DATA, C_SETUP, C_ACCESS, C_RESP} cmd_state_e;

  logic                rx_meta_q, rx_sync_q;
  rx_state_e           rx_state_q, rx_state_d;
  logic [CW-1:0]       rx_cnt_q, rx_cnt_d;
  logic [2:0]          rx_bit_q, rx_bit_d;
  logic [7:0]          rx_shift_q, rx_shift_d;
  logic                rx_valid_q, rx_valid_d, rx_ferr_q, rx_ferr_d;

  tx_state_e           tx_state_q, tx_state_d;
  logic [CW-1:0]       tx_cnt_q, tx_cnt_d;
  logic [2:0]          tx_bit_q, tx_bit_d;
  logic [7:0]          tx_shift_q, tx_shift_d;
  logic                tx_q, tx_d, tx_done_q, tx_done_d;
  logic                tx_start_q, tx_start_d;

  cmd_state_e          cmd_state_q, cmd_state_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic                is_write_q, is_write_d;
  logic [APB_ADDR_WIDTH-1:0] addr_sh_q, addr_sh_d, addr_next_s;
  logic [31:0]         data_sh_q, data_sh_d, data_next_s;
  logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [31:0]         pwdata_q, pwdata_d;
  logic                pwrite_q, pwrite_d, psel_q, psel_d, penable_q, penable_d;
  logic [39:0]         resp_sh_q, resp_sh_d;
  logic [2:0]          resp_left_q, resp_left_d;
  logic                busy_q;
  logic                timeout_s;

  // Two-flop synchronizer, reset to line idle so reset release never looks like a start bit
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
    end
  end

  // RX framing: start re-checked at half bit, data and stop sampled at mid-bit
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_valid_d = 1'b0;
    rx_ferr_d  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        rx_bit_d = 3'd0;
        if (!rx_sync_q) rx_state_d = RX_START;
        else            rx_state_d = RX_IDLE;
      end
      RX_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d = '0;
          if (!rx_sync_q) rx_state_d = RX_DATA;
          else            rx_state_d = RX_IDLE;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          else                  rx_state_d = RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_IDLE;
          if (rx_sync_q) rx_valid_d = 1'b1;
          else           rx_ferr_d  = 1'b1;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // TX serializer; tx_q is the registered line driver
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
    tx_done_d  = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        tx_d     = 1'b1;
        tx_cnt_d = '0;
        tx_bit_d = 3'd0;
        if (tx_start_q) begin
          tx_shift_d = resp_sh_q[39:32];
          tx_d       = 1'b0;
          tx_state_d = TX_START;
        end else begin
          tx_state_d = TX_IDLE;
        end
      end
      TX_START: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_d       = tx_shift_q[0];
          tx_state_d = TX_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_d       = 1'b1;
            tx_state_d = TX_STOP;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_d       = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_done_d  = 1'b1;
          tx_state_d = TX_IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

`ifdef UART_APB_MASTER_TIMEOUT_EN
  localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW = $clog2(TO_LIMIT + 1);
  logic [TW-1:0] to_cnt_q, to_cnt_d;

  // Inter-byte silence counter, only running while a command is partially received
  always_comb begin
    if (rx_valid_q || !((cmd_state_q == C_ADDR) || (cmd_state_q == C_DATA))) begin
      to_cnt_d = '0;
    end else begin
      to_cnt_d = to_cnt_q + TW'(1);
    end
  end

  // Timeout counter register
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) to_cnt_q <= '0;
    else       to_cnt_q <= to_cnt_d;
  end

  assign timeout_s = (to_cnt_q == TW'(TO_LIMIT - 1)) && !rx_valid_q;
`else
  assign timeout_s = 1'b0;
`endif

  assign addr_next_s = APB_ADDR_WIDTH'({addr_sh_q, rx_shift_q});
  assign data_next_s = {data_sh_q[23:0], rx_shift_q};

  // Command FSM: collect bytes, run one APB transfer, stream the response
  always_comb begin
    cmd_state_d = cmd_state_q;
    byte_cnt_d  = byte_cnt_q;
    is_write_d  = is_write_q;
    addr_sh_d   = addr_sh_q;
    data_sh_d   = data_sh_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pwrite_d    = pwrite_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    resp_sh_d   = resp_sh_q;
    resp_left_d = resp_left_q;
    tx_start_d  = 1'b0;
    case (cmd_state_q)
      C_IDLE: begin
        byte_cnt_d = 2'd0;
        if (rx_valid_q) begin
          if (rx_shift_q == CMD_WRITE) begin
            is_write_d  = 1'b1;
            cmd_state_d = C_ADDR;
          end else if (rx_shift_q == CMD_READ) begin
            is_write_d  = 1'b0;
            cmd_state_d = C_ADDR;
          end else begin
            resp_sh_d   = {RSP_UNKNOWN, 32'h0000_0000};
            resp_left_d = 3'd0;
            tx_start_d  = 1'b1;
            cmd_state_d = C_RESP;
          end
        end else begin
          cmd_state_d = C_IDLE;
        end
      end
      C_ADDR: begin
        if (rx_ferr_q || timeout_s) begin
          cmd_state_d = C_IDLE;
        end else if (rx_valid_q) begin
          addr_sh_d = addr_next_s;
          if (byte_cnt_q == 2'd1) begin
            byte_cnt_d = 2'd0;
            if (is_write_q) begin
              cmd_state_d = C_DATA;
            end else begin
              paddr_d     = addr_next_s;
              pwrite_d    = 1'b0;
              psel_d      = 1'b1;
              cmd_state_d = C_SETUP;
            end
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end else begin
          cmd_state_d = C_ADDR;
        end
      end
      C_DATA: begin
        if (rx_ferr_q || timeout_s) begin
          cmd_state_d = C_IDLE;
        end else if (rx_valid_q) begin
          data_sh_d = data_next_s;
          if (byte_cnt_q == 2'd3) begin
            byte_cnt_d  = 2'd0;
            paddr_d     = addr_sh_q;
            pwdata_d    = data_next_s;
            pwrite_d    = 1'b1;
            psel_d      = 1'b1;
            cmd_state_d = C_SETUP;
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end else begin
          cmd_state_d = C_DATA;
        end
      end
      C_SETUP: begin
        penable_d   = 1'b1;
        cmd_state_d = C_ACCESS;
      end
      C_ACCESS: begin
        if (PREADY) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          resp_sh_d   = {(PSLVERR ? RSP_ERR : RSP_OK), (is_write_q ? 32'h0000_0000 : PRDATA)};
          resp_left_d = is_write_q ? 3'd0 : 3'd4;
          tx_start_d  = 1'b1;
          cmd_state_d = C_RESP;
        end else begin
          cmd_state_d = C_ACCESS;
        end
      end
      C_RESP: begin
        if (tx_done_q) begin
          if (resp_left_q == 3'd0) begin
            cmd_state_d = C_IDLE;
          end else begin
            resp_left_d = resp_left_q - 3'd1;
            resp_sh_d   = {resp_sh_q[31:0], 8'h00};
            tx_start_d  = 1'b1;
          end
        end else begin
          cmd_state_d = C_RESP;
        end
      end
      default: cmd_state_d = C_IDLE;
    endcase
  end

  // State and output registers for all three engines
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= 3'd0;
      rx_shift_q  <= 8'h00;
      rx_valid_q  <= 1'b0;
      rx_ferr_q   <= 1'b0;
      tx_state_q  <= TX_IDLE;
      tx_cnt_q    <= '0;
      tx_bit_q    <= 3'd0;
      tx_shift_q  <= 8'h00;
      tx_q        <= 1'b1;
      tx_done_q   <= 1'b0;
      tx_start_q  <= 1'b0;
      cmd_state_q <= C_IDLE;
      byte_cnt_q  <= 2'd0;
      is_write_q  <= 1'b0;
      addr_sh_q   <= '0;
      data_sh_q   <= 32'h0000_0000;
      paddr_q     <= '0;
      pwdata_q    <= 32'h0000_0000;
      pwrite_q    <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      resp_sh_q   <= 40'h00_0000_0000;
      resp_left_q <= 3'd0;
      busy_q      <= 1'b0;
    end else begin
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      rx_valid_q  <= rx_valid_d;
      rx_ferr_q   <= rx_ferr_d;
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_shift_q  <= tx_shift_d;
      tx_q        <= tx_d;
      tx_done_q   <= tx_done_d;
      tx_start_q  <= tx_start_d;
      cmd_state_q <= cmd_state_d;
      byte_cnt_q  <= byte_cnt_d;
      is_write_q  <= is_write_d;
      addr_sh_q   <= addr_sh_d;
      data_sh_q   <= data_sh_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pwrite_q    <= pwrite_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      resp_sh_q   <= resp_sh_d;
      resp_left_q <= resp_left_d;
      busy_q      <= (cmd_state_d != C_IDLE);
    end
  end

  assign tx_o    = tx_q;
  assign PADDR   = paddr_q;
  assign PWDATA  = pwdata_q;
  assign PWRITE  = pwrite_q;
  assign PSEL    = psel_q;
  assign PENABLE = penable_q;
  assign busy_o  = busy_q;

endmodule
